// File: rtl/pipe_add_ctrl_if.sv
// rtl/pipe_add_ctrl_if.sv - handshake, hold/error and status bundle of the adder pipeline controller
interface pipe_add_ctrl_if #(
   parameter int LAYERS    = 2,
   parameter int CNT_WIDTH = 8
);
   localparam int SW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

   logic                 in_valid;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [LAYERS-1:0]    error_signals;
   logic [LAYERS-1:0]    hold_signals;
   logic                 err_flag;
   logic [SW-1:0]        err_stage;
   logic [CNT_WIDTH-1:0] err_count;
   logic                 err_clear;
   logic                 flushing;

   modport master (
      input  in_valid, out_ready, error_signals, err_clear,
      output in_ready, out_valid, hold_signals, err_flag, err_stage, err_count, flushing
   );

   modport slave (
      output in_valid, out_ready, error_signals, err_clear,
      input  in_ready, out_valid, hold_signals, err_flag, err_stage, err_count, flushing
   );
endinterface

// File: rtl/pipe_add_ctrl.sv
// rtl/pipe_add_ctrl.sv - flow control and parity-error recovery for the cascaded adder pipeline
module pipe_add_ctrl #(
   parameter int LAYERS    = 2,
   parameter int CNT_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   pipe_add_ctrl_if.master   bus
);
   localparam int SW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
   localparam int FW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'(LAYERS - 1);

   typedef enum logic {ST_FLUSH, ST_RUN} state_t;

   state_t               state_q;
   logic [FW-1:0]        fcnt_q;
   logic [LAYERS-1:0]    valid_q;
   logic [LAYERS-1:0]    valid_d;
   logic [LAYERS-1:0]    adv;
   logic [LAYERS-1:0]    live_err;
   logic                 run;
   logic                 det;
   logic                 chain;
   logic [SW-1:0]        stage_d;
   logic                 err_flag_q;
   logic [SW-1:0]        err_stage_q;
   logic [CNT_WIDTH-1:0] err_count_q;

   always_comb begin
      run      = ~rst & (state_q == ST_RUN);
      live_err = bus.error_signals & valid_q;
      det      = run & (|live_err);

      // Advance ripples back from the output so empty layers collapse bubbles.
      chain = bus.out_ready;
      adv   = '0;
      for (int k = LAYERS - 1; k >= 0; k--) begin
         chain  = ~valid_q[k] | chain;
         adv[k] = chain;
      end

      stage_d = '0;
      for (int k = LAYERS - 1; k >= 0; k--) begin
         if (live_err[k]) stage_d = SW'(k);
      end

      valid_d = valid_q;
      if (adv[0]) valid_d[0] = bus.in_valid;
      for (int k = 1; k < LAYERS; k++) begin
         if (adv[k]) valid_d[k] = valid_q[k-1];
      end
   end

   assign bus.in_ready     = run & ~det & adv[0];
   assign bus.out_valid    = run & ~det & valid_q[LAYERS-1];
   assign bus.hold_signals = (run & ~det) ? ~adv : '0;
   assign bus.flushing     = rst | (state_q == ST_FLUSH);
   assign bus.err_flag     = err_flag_q;
   assign bus.err_stage    = err_stage_q;
   assign bus.err_count    = err_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FLUSH;
         fcnt_q      <= '0;
         valid_q     <= '0;
         err_flag_q  <= 1'b0;
         err_stage_q <= '0;
         err_count_q <= '0;
      end else begin
         case (state_q)
            ST_FLUSH: begin
               valid_q <= '0;
               if (fcnt_q == FLUSH_LAST) begin
                  state_q <= ST_RUN;
                  fcnt_q  <= '0;
               end else begin
                  fcnt_q <= fcnt_q + FW'(1);
               end
            end
            ST_RUN: begin
               if (det) begin
                  valid_q <= '0;
                  state_q <= ST_FLUSH;
                  fcnt_q  <= '0;
               end else begin
                  valid_q <= valid_d;
               end
            end
            default: state_q <= ST_FLUSH;
         endcase

         // A new event outranks a simultaneous clear.
         if (det) begin
            err_flag_q  <= 1'b1;
            err_stage_q <= stage_d;
            if (bus.err_clear)      err_count_q <= CNT_WIDTH'(1);
            else if (!(&err_count_q)) err_count_q <= err_count_q + CNT_WIDTH'(1);
         end else if (bus.err_clear) begin
            err_flag_q  <= 1'b0;
            err_stage_q <= '0;
            err_count_q <= '0;
         end
      end
   end
endmodule

// File: doc/pipe_add_ctrl.md
# pipe_add_ctrl

Flow-control and error-recovery controller for the cascaded parity-protected adder pipeline. It drives the per-layer `hold_signals` of the pipeline from a valid/ready handshake and tracks which layers hold live data. It monitors the per-layer parity `error_signals`. On a parity error in a live layer it discards the corrupted data, scrubs every pipeline register, and reports the event through a sticky flag and a counter. It sits between the upstream producer, the downstream consumer and the adder chain, and replaces the free-running `checker` alarm logic.

## Interface
Parameters:
- `LAYERS`, 2, number of cascaded adder layers (≥1); matches the pipeline depth.
- `CNT_WIDTH`, 8, width of the error counter.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `in_valid`  input  1  upstream word present on the pipeline input.
- `in_ready`  output  1  layer 0 accepts the input word this cycle.
- `out_valid`  output  1  result on the pipeline output (`sum`) is valid.
- `out_ready`  input  1  downstream consumes the result this cycle.
- `error_signals`  input  LAYERS  per-layer parity mismatch from the pipeline; bit k is layer k.
- `hold_signals`  output  LAYERS  per-layer hold to the pipeline; 1 means the layer keeps its contents.
- `err_flag`  output  1  sticky: a parity error on live data has occurred.
- `err_stage`  output  $clog2(LAYERS)  lowest layer index of the most recent error event.
- `err_count`  output  CNT_WIDTH  number of error events; saturates.
- `err_clear`  input  1  clears `err_flag`, `err_stage` and `err_count`.
- `flushing`  output  1  controller is in the FLUSH state.

## Operation
- State: `valid[LAYERS-1:0]`, FSM {FLUSH, RUN}, flush counter, error registers.
- Advance terms in RUN:
  - `adv[L-1] = ~valid[L-1] | out_ready`.
  - `adv[k] = ~valid[k] | adv[k+1]` for k < L-1.
  - `hold_signals[k] = ~adv[k]`.
  - A layer without live data is never held, so its registers and parity are continuously refreshed.
- Handshake in RUN, with no error detected:
  - `in_ready = adv[0]` and `out_valid = valid[L-1]`.
  - On the clock, `valid[0] <= in_valid` if `adv[0]`; `valid[k] <= valid[k-1]` if `adv[k]`.
  - A held layer keeps its valid bit.
- Error detection: `det = |(error_signals & valid)`, evaluated only in RUN.
  - Errors on layers with `valid[k]=0` are ignored.
- When `det=1`, in the same cycle:
  - `in_ready=0` and `out_valid=0`; a corrupted result is never presented.
  - All holds are driven to 0.
- On the clock edge after `det=1`:
  - All valid bits cleared.
  - `err_flag<=1`.
  - `err_stage` <= lowest k with `error_signals[k] & valid[k]`.
  - `err_count` incremented, saturating at all-ones.
  - FSM enters FLUSH.
  - Simultaneous errors in several layers count as one event.
- FLUSH lasts exactly LAYERS cycles:
  - `hold_signals` all 0, `in_ready=0`, `out_valid=0`, `flushing=1`.
  - `error_signals` ignored.
  - The layers load fresh data and parity; data in flight is lost and the producer must resend.
  - After LAYERS cycles the FSM returns to RUN with all valid bits 0.
- `err_clear` in the same cycle as a new event: the new event wins (`err_flag=1`, `err_count=1`, `err_stage` = new index).

## Timing
- While `rst`=1:
  - `valid`=0, `in_ready`=0, `out_valid`=0, `hold_signals`=0, `flushing`=1.
  - `err_flag`=0, `err_stage`=0, `err_count`=0.
  - FSM forced to FLUSH with the counter reset.
- After `rst` deasserts, FLUSH runs LAYERS cycles and then RUN starts. The reset flush does not count as an error.
- `rst` mid-operation discards all in-flight words and all error state, with no output pulse.
- Latency: a word accepted at edge t appears with `out_valid=1` after edge t+LAYERS-1 (layer L-1 loaded), absent stalls.
- Throughput: one word per cycle while `out_ready=1`.
- Combinational paths:
  - `out_ready` → `hold_signals`/`in_ready`: full bubble-collapsing, no skid buffer.
  - `error_signals` → `in_ready`/`out_valid`/`hold_signals`.
- Pipeline full with `out_ready=0`:
  - All holds are 1 and `in_ready=0`.
  - Contents and parity stay frozen; an error detected while frozen still triggers recovery.

## Test plan
- Reset, LAYERS=2: hold `rst` 3 cycles, release → `flushing`=1 for exactly 2 cycles, then `in_ready`=1, `err_count`=0, holds 00.
- Streaming: `in_valid`=1 and `out_ready`=1 continuously with inputs 1,2,3… → `out_valid` rises 2 edges after the first acceptance, then one result per cycle with no bubbles; holds stay 00.
- Backpressure: fill the pipe, drop `out_ready` for 4 cycles → holds=11, `in_ready`=0, output stable. Raise `out_ready` → the stream resumes with no loss or duplication.
- Bubble collapse: `valid`={L1=1, L0=0}, `out_ready`=0, `in_valid`=1 → hold[0]=0, word accepted, next cycle holds=11.
- Error on live layer 1: force `error_signals`=10 with `valid[1]`=1 → same cycle `out_valid`=0 and `in_ready`=0. Then `err_flag`=1, `err_stage`=1, `err_count`=1, FLUSH for 2 cycles, valid cleared.
- Ignored error and clear: force `error_signals`=01 with `valid[0]`=0 → no reaction. Then pulse `err_clear` together with a live error on layer 0 → `err_flag`=1, `err_count`=1, `err_stage`=0.
